ee357_arb_mux: RTL and testbench



---
 rtl/ee357_mux_pkg.sv | 18 +
 rtl/ee357_arb_mux_if.sv | 32 +++
 rtl/ee357_rr_arbiter.sv | 33 +++
 rtl/ee357_arb_mux.sv | 115 +++++++++++
 tb/tb_ee357_arb_mux.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ee357_mux_pkg.sv
// Shared definitions for the ee357 arbitrated multiplexer.
//   MODE_SEL / MODE_RR : values of sel_en selecting explicit or round-robin mode
//   clog2()            : constant function used for parameter consistency checks
package ee357_mux_pkg;

  localparam logic MODE_SEL = 1'b1;
  localparam logic MODE_RR  = 1'b0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/ee357_arb_mux_if.sv
// Handshake bundle of ee357_arb_mux.
//   in_data/in_valid/in_ready : NUM_IN producer channels, channel i at [i*WIDTH +: WIDTH]
//   sel/sel_en                : explicit select and mode
//   out_data/out_sel/out_valid/out_ready : registered output channel
// Modports: slave = the mux itself, master = the environment driving it.
interface ee357_arb_mux_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    sel_en;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_data, in_valid, sel, sel_en, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, sel, sel_en, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/ee357_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, one bit per channel
//   ptr       : highest-priority channel for this cycle
//   grant     : index of the first requesting channel at or after ptr (wrapping)
//   grant_vld : some channel is requesting
module ee357_rr_arbiter #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_vld
);

  int unsigned idx;

  // Equivalent to rotate-by-ptr, priority-encode, unrotate: offsets are scanned
  // from farthest to nearest so the channel closest to ptr is the last to win.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int unsigned k = NUM_IN; k > 0; k--) begin
      idx = (32'(ptr) + k - 1) % NUM_IN;
      if (req[idx]) begin
        grant     = SEL_W'(idx);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ee357_arb_mux.sv
// N-input W-bit multiplexer with a registered output stage and valid/ready
// handshakes. Source chosen by explicit select (sel_en=1) or round-robin (sel_en=0).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ee357_arb_mux_if slave modport (inputs, selects, output channel)
module ee357_arb_mux
  import ee357_mux_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input logic               clk,
  input logic               rst_n,
  ee357_arb_mux_if.slave    bus
);

  localparam int unsigned SEL_SPAN = 1 << SEL_W;

  if (SEL_W != clog2(NUM_IN)) begin : g_bad_sel_w
    $error("ee357_arb_mux: SEL_W must equal clog2(NUM_IN)");
  end
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("ee357_arb_mux: NUM_IN must be in 2..16");
  end

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                load_ok;
  logic                transfer;
  logic [SEL_W-1:0]    rr_grant;
  logic                rr_grant_vld;
  logic [SEL_W-1:0]    grant;
  logic                grant_vld;
  logic [SEL_SPAN-1:0] valid_pad;
  logic [WIDTH-1:0]    data_sel;

  ee357_rr_arbiter #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .grant     (rr_grant),
    .grant_vld (rr_grant_vld)
  );

  assign load_ok = !out_valid_q || bus.out_ready;

  always_comb begin
    // Padded so a select beyond NUM_IN-1 indexes a defined zero bit.
    valid_pad              = '0;
    valid_pad[NUM_IN-1:0]  = bus.in_valid;
    if (bus.sel_en == MODE_SEL) begin
      grant     = bus.sel;
      grant_vld = (32'(bus.sel) < NUM_IN) && valid_pad[bus.sel];
    end else begin
      grant     = rr_grant;
      grant_vld = rr_grant_vld;
    end
  end

  // rst_n gates the handshake so no producer sees an accept while in reset.
  assign transfer = rst_n && load_ok && grant_vld;

  always_comb begin
    bus.in_ready = '0;
    data_sel     = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant == SEL_W'(i)) begin
        bus.in_ready[i] = transfer;
        data_sel        = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (transfer) begin
      out_data_d  = data_sel;
      out_sel_d   = grant;
      out_valid_d = 1'b1;
      if (bus.sel_en == MODE_RR) begin
        rr_ptr_d = (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_ee357_arb_mux.sv
// Self-checking bench for ee357_arb_mux: directed scenarios followed by a
// randomized phase, all compared against a cycle-level behavioural model.
module tb_ee357_arb_mux;
  import ee357_mux_pkg::*;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NUM_IN = 4;
  localparam int unsigned SEL_W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ee357_arb_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

  ee357_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_ptr;

  // Values observed at the most recent mid-cycle sample
  logic [3:0]  obs_ready;
  logic        obs_valid;
  logic [31:0] obs_data;
  logic [1:0]  obs_sel;
  logic [3:0]  xfer_vec;

  int exp_all[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_odd[4] = '{1, 3, 1, 3};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endfunction

  // Which channel the rules pick: sel directly, or first valid scanning from ptr.
  function automatic int m_grant(input logic [3:0] v, input logic se, input logic [1:0] s,
                                 output bit vld);
    int g;
    bit found;
    g = 0;
    found = 1'b0;
    if (se) begin
      g = int'(s);
      found = (g < NUM_IN) && v[g];
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        int c;
        c = (m_ptr + k) % NUM_IN;
        if (!found && v[c]) begin
          g = c;
          found = 1'b1;
        end
      end
    end
    vld = found;
    return g;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Sample mid-cycle, compare with the model, advance the model, move past the edge.
  task automatic cycle();
    bit vld;
    int g;
    bit load;
    logic [3:0] rexp;
    @(negedge clk);
    if (!rst_n) m_reset();
    obs_ready = bus.in_ready;
    obs_valid = bus.out_valid;
    obs_data  = bus.out_data;
    obs_sel   = bus.out_sel;
    g    = m_grant(bus.in_valid, bus.sel_en, bus.sel, vld);
    load = !m_valid || bus.out_ready;
    rexp = (rst_n && load && vld) ? 4'(1 << g) : 4'b0000;
    chk("in_ready", 64'(obs_ready), 64'(rexp));
    chk("out_valid", 64'(obs_valid), 64'(m_valid));
    chk("out_data", 64'(obs_data), 64'(m_data));
    chk("out_sel", 64'(obs_sel), 64'(m_sel));
    xfer_vec = rexp;
    if (rst_n && load && vld) begin
      m_valid = 1'b1;
      m_data  = bus.in_data[g*WIDTH +: WIDTH];
      m_sel   = g;
      if (bus.sel_en == MODE_RR) m_ptr = (g + 1) % NUM_IN;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_reset();
    for (int i = 0; i < NUM_IN; i++) bus.in_data[i*WIDTH +: WIDTH] = 32'hCAFE_0000 | i;
    bus.in_valid  = 4'b1111;
    bus.sel       = '0;
    bus.sel_en    = MODE_RR;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // Reset held with every channel valid: nothing accepted, outputs zero.
    repeat (3) cycle();
    chk("rst_ready", 64'(obs_ready), 64'(0));
    #2 rst_n = 1'b1;

    // Round-robin over all channels, then only channels 1 and 3.
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_all", 64'(onehot_idx(obs_ready)), 64'(exp_all[k]));
    end
    bus.in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_odd", 64'(onehot_idx(obs_ready)), 64'(exp_odd[k]));
    end

    // Backpressure, then drain and reload without a bubble (pointer back at 0).
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("bp_ready", 64'(obs_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("no_bubble_ready", 64'(obs_ready), 64'(4'b0001));
    chk("no_bubble_valid", 64'(obs_valid), 64'(1));

    // Explicit select of channel 2.
    bus.sel_en = MODE_SEL;
    bus.sel    = 2'd2;
    repeat (4) begin
      cycle();
      chk("sel2_ready", 64'(obs_ready), 64'(4'b0100));
    end
    cycle();
    chk("sel2_data", 64'(obs_data), 64'(32'hCAFE_0002));
    chk("sel2_sel", 64'(obs_sel), 64'(2));

    // Explicit select of an idle channel, then it becomes valid.
    bus.sel      = 2'd3;
    bus.in_valid = 4'b0111;
    cycle();
    chk("idle_ready", 64'(obs_ready), 64'(0));
    cycle();
    chk("idle_drained", 64'(obs_valid), 64'(0));
    bus.in_valid = 4'b1111;
    cycle();
    chk("sel3_ready", 64'(obs_ready), 64'(4'b1000));
    cycle();
    chk("sel3_valid", 64'(obs_valid), 64'(1));
    chk("sel3_sel", 64'(obs_sel), 64'(3));

    // Move the pointer to 2, hold a word, then reset asynchronously.
    bus.sel_en   = MODE_RR;
    bus.in_valid = 4'b0010;
    cycle();
    bus.out_ready = 1'b0;
    bus.in_valid  = 4'b1111;
    cycle();
    chk("pre_rst_valid", 64'(obs_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'(0));
    chk("async_rst_ready", 64'(bus.in_ready), 64'(0));
    m_reset();
    cycle();
    #2 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    chk("restart_ch0", 64'(obs_ready), 64'(4'b0001));

    // Randomized traffic; producers hold valid/data until accepted.
    for (int n = 0; n < 400; n++) begin
      bus.sel_en    = ($urandom_range(0, 3) == 0) ? MODE_SEL : MODE_RR;
      bus.sel       = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      for (int i = 0; i < NUM_IN; i++) begin
        if (xfer_vec[i]) bus.in_valid[i] = 1'b0;
        if (!bus.in_valid[i] && $urandom_range(0, 1) == 1) begin
          bus.in_valid[i] = 1'b1;
          bus.in_data[i*WIDTH +: WIDTH] = $urandom;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
